// File: rtl/serial_deframer.sv
// serial_deframer: hunts SYNC_WORD in a serial bit stream, then assembles PAYLOAD_WORDS words onto a valid/ready port.
// Define SERIAL_DEFRAMER_PARITY_EN to expect an even-parity bit after each word and expose parity_err.
module serial_deframer #(
   parameter int                DATA_W        = 8,
   parameter logic [DATA_W-1:0] SYNC_WORD     = 8'hA5,
   parameter int                PAYLOAD_WORDS = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               din,
   input  logic                               din_en,
   input  logic                               out_ready,
   output logic [DATA_W-1:0]                  out_data,
   output logic                               out_valid,
   output logic                               locked,
   output logic                               overflow,
`ifdef SERIAL_DEFRAMER_PARITY_EN
   output logic                               parity_err,
`endif
   output logic [$clog2(PAYLOAD_WORDS+1)-1:0] word_cnt
);
   localparam int CW = $clog2(PAYLOAD_WORDS + 1);
   localparam int BW = $clog2(DATA_W);
`ifdef SERIAL_DEFRAMER_PARITY_EN
   typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;
`else
   typedef enum logic {HUNT, COLLECT} state_t;
`endif
   state_t            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d, acc_q, acc_d, out_data_q, out_data_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]     word_cnt_q, word_cnt_d;
   logic              out_valid_q, out_valid_d, overflow_q, overflow_d;
   logic              parity_err_q, parity_err_d;
   logic              deliver;
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      acc_d        = acc_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q && !out_ready;
      overflow_d   = overflow_q;
      parity_err_d = 1'b0;
      deliver      = 1'b0;
      case (state_q)
         HUNT: if (din_en) begin
            sr_d = {sr_q[DATA_W-2:0], din};
            if (sr_d == SYNC_WORD) begin
               state_d    = COLLECT;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
            end
         end
         // Frame end burns one cycle here; sr restarts empty so payload bits cannot fake a sync.
         COLLECT: if (word_cnt_q == CW'(PAYLOAD_WORDS)) begin
            state_d = HUNT;
            sr_d    = '0;
         end else if (din_en) begin
            acc_d     = {acc_q[DATA_W-2:0], din};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_W - 1)) begin
               bit_cnt_d = '0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
               state_d = CHECK;
`else
               word_cnt_d = word_cnt_q + 1'b1;
               deliver    = 1'b1;
`endif
            end
         end
`ifdef SERIAL_DEFRAMER_PARITY_EN
         CHECK: if (din_en) begin
            state_d      = COLLECT;
            word_cnt_d   = word_cnt_q + 1'b1;
            deliver      = ~(^acc_q ^ din);
            parity_err_d = ^acc_q ^ din;
         end
`endif
         default: state_d = HUNT;
      endcase
      if (deliver) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = acc_d;
            out_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         sr_q         <= '0;
         acc_q        <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         acc_q        <= acc_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
      end
   end
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;
   assign locked    = (state_q != HUNT);
   assign word_cnt  = word_cnt_q;
`ifdef SERIAL_DEFRAMER_PARITY_EN
   assign parity_err = parity_err_q;
`else
   logic unused_parity;
   assign unused_parity = parity_err_q;
`endif
endmodule

// File: doc/serial_deframer.md
# serial_deframer

Serial-to-parallel deframer sitting directly downstream of the `d_flip_flip` registered bit stage. It consumes the registered serial bit, hunts for a sync word, and assembles the following payload bits into parallel words. Each word is presented on a valid/ready output port. After a fixed number of payload words it returns to hunting.

## Interface
- `DATA_W`, default 8: width of sync word and of each payload word (≥2).
- `SYNC_WORD`, default 8'hA5: frame marker matched MSB-first.
- `PAYLOAD_WORDS`, default 4: payload words per frame (≥1).

- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `din` input 1: serial bit, driven by the registered bit stage's `q`.
- `din_en` input 1: `din` is sampled only when high.
- `out_ready` input 1: downstream accepts `out_data` this cycle.
- `out_data` output DATA_W: assembled word, MSB = first received bit.
- `out_valid` output 1: `out_data` holds an unconsumed word.
- `locked` output 1: high while in frame (not hunting).
- `overflow` output 1: sticky; a completed word was dropped.
- `word_cnt` output clog2(PAYLOAD_WORDS+1): words completed in current frame.

## Operation
- States: HUNT, COLLECT (plus CHECK when parity is compiled in).
- HUNT: on `din_en`, `sr <= {sr[DATA_W-2:0], din}`. When the new `sr` value equals SYNC_WORD, go to COLLECT with bit_cnt=0 and word_cnt=0.
- COLLECT: on `din_en`, shift `din` into `acc` and increment bit_cnt. On the DATA_W-th bit, the word completes: bit_cnt returns to 0 and word_cnt increments.
- Completed word delivery:
  - If the output register is empty, or is being consumed this cycle (`out_valid && out_ready`), load `out_data` and keep/set `out_valid=1`.
  - Otherwise drop the word and set `overflow=1`.
  - A dropped word still counts toward word_cnt.
- When word_cnt reaches PAYLOAD_WORDS, go to HUNT the next cycle. Clear `sr` to 0 so the sync search restarts fresh (no overlap with payload bits).
- Output handshake: `out_valid` falls only on `out_valid && out_ready` with no simultaneous load. `out_data` is stable while `out_valid && !out_ready`.
- A pending output word survives the frame end and HUNT; it is discarded only by reset.
- `din_en=0` freezes all shift registers and counters. The output handshake still operates.
- `locked` = (state != HUNT). `word_cnt` holds its last value in HUNT until the next sync match clears it.

## Timing
- Reset values (cycle after `rst_n` sampled low): state=HUNT, `sr`=0, `acc`=0, `out_data`=0, `out_valid`=0, `locked`=0, `overflow`=0, `word_cnt`=0.
- Reset mid-frame aborts the frame immediately and discards any pending word.
- Sync match: the last sync bit is sampled at edge N, and `locked`=1 after edge N.
- Word latency: the last data bit is sampled at edge N, and `out_valid`=1 with the word after edge N (1-cycle register latency).
- Frame end: the final word completes at edge N, and `locked`=0 after edge N+1 (one extra cycle in COLLECT).
- Back-to-back words with continuous `din_en` and `out_ready=1`: one word every DATA_W cycles, with no bubbles.

## Configuration
- `SERIAL_DEFRAMER_PARITY_EN` defined:
  - Each payload word is followed by one even-parity bit, received in CHECK state. The word plus parity bit must contain an even number of ones.
  - On a match, the word is delivered per the rules above.
  - On a mismatch, the word is dropped, `overflow` is unaffected, and word_cnt still increments. An extra output `parity_err` (1 bit, reset 0) pulses high for one cycle.
  - The word becomes available one `din_en` bit later than without parity.
- Not defined: no parity bit, no CHECK state, no `parity_err` port.

## Test plan
- Reset, then stream 0x3C, 0xA5, 0x11, 0x22, 0x33, 0x44 MSB-first with `din_en=1` and `out_ready=1` -> `locked` rises after the last A5 bit. `out_data` shows 0x11, 0x22, 0x33, 0x44, each valid one cycle after its last bit. `locked` falls one cycle after the 0x44 word completes.
- Same frame with `out_ready=0` throughout -> 0x11 is held on `out_data`. 0x22 to 0x44 are dropped and `overflow`=1. Raising `out_ready` then clears `out_valid` after one cycle.
- `din_en` toggling 1/0 every cycle during the frame -> identical words delivered, at half the rate.
- Assert `rst_n=0` after 0x11 is delivered and 4 bits of 0x22 are received -> all outputs return to reset values next cycle. A fresh A5 frame then decodes correctly.
- Bit pattern 0xA4 followed by payload -> no lock and `out_valid` stays 0.
- With `SERIAL_DEFRAMER_PARITY_EN`: A5, then 0x11+parity 0, then 0x22+parity 1 (bad) -> 0x11 delivered, `parity_err` pulses once, 0x22 not delivered, word_cnt=2.
